// File: rtl/passcode_ctrl_pkg.sv
// Shared types and constants for the passcode controller.
// Holds the FSM state encoding, the keypad codes and a small sizing helper.
package passcode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_RESULT,
        ST_LOCK
    } state_t;

    typedef logic [3:0] key_t;

    localparam key_t KEY_CLR = 4'd8;
    localparam key_t KEY_ENT = 4'd9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/passcode_ctrl_if.sv
// Keypad event input and status outputs of the passcode controller.
// The slave side is the controller; the master side is the keypad/host.
interface passcode_ctrl_if;
    import passcode_ctrl_pkg::*;

    logic       key_vld;
    key_t       key_val;
    logic [2:0] count;
    logic [2:0] key_num;
    logic       inputing;
    logic       input_finish;
    logic       success;
    logic       alarm;

    modport master (
        output key_vld, key_val,
        input  count, key_num, inputing, input_finish, success, alarm
    );

    modport slave (
        input  key_vld, key_val,
        output count, key_num, inputing, input_finish, success, alarm
    );

endinterface

// File: rtl/passcode_ctrl_cyc_timer.sv
// Loadable down-counter that saturates at zero; done marks the last counted cycle.
// A load of N makes done high during the Nth cycle after the load edge.
module cyc_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign done = (cnt == ONE);

endmodule

// File: rtl/passcode_ctrl.sv
// Passcode entry controller: collects 3-bit digits from a keypad, compares them
// with PASSCODE, shows the result and locks out after repeated failures.
module passcode_ctrl
    import passcode_ctrl_pkg::*;
#(
    parameter int                    CODE_LEN    = 4,
    parameter logic [CODE_LEN*3-1:0] PASSCODE    = 12'o1234,
    parameter int                    TIMEOUT_CYC = 250_000_000,
    parameter int                    HOLD_CYC    = 150_000_000,
    parameter int                    MAX_FAIL    = 3,
    parameter int                    LOCK_CYC    = 500_000_000
) (
    input  logic           clk,
    input  logic           rst,
    passcode_ctrl_if.slave pif
);

    localparam int DIG_W  = CODE_LEN * 3;
    localparam int TMR_W  = $clog2(max3(TIMEOUT_CYC, HOLD_CYC, LOCK_CYC) + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [2:0]        LEN      = 3'(CODE_LEN);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_ONE = FAIL_W'(1);
    localparam logic [TMR_W-1:0]  T_TOUT   = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0]  T_HOLD   = TMR_W'(HOLD_CYC);
    localparam logic [TMR_W-1:0]  T_LOCK   = TMR_W'(LOCK_CYC);

    state_t            state, state_nxt;
    logic [DIG_W-1:0]  digits, digits_nxt, digit_shift;
    logic [2:0]        count_nxt, key_num_nxt;
    logic              success_nxt;
    logic [FAIL_W-1:0] fail_cnt, fail_nxt;
    logic              tmr_load, tmr_done;
    logic [TMR_W-1:0]  tmr_val;
    logic              is_digit;

    assign is_digit = pif.key_vld && !pif.key_val[3];

    // One timer serves entry timeout, result hold and lockout; only one is live per state.
    cyc_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        digits_nxt  = digits;
        count_nxt   = pif.count;
        key_num_nxt = pif.key_num;
        success_nxt = pif.success;
        fail_nxt    = fail_cnt;
        tmr_load    = 1'b0;
        tmr_val     = T_TOUT;
        digit_shift = digits << 3;
        digit_shift[2:0] = pif.key_val[2:0];

        case (state)
            ST_IDLE: begin
                if (is_digit) begin
                    state_nxt   = ST_ENTRY;
                    digits_nxt  = DIG_W'(pif.key_val[2:0]);
                    count_nxt   = 3'd1;
                    key_num_nxt = pif.key_val[2:0];
                    tmr_load    = 1'b1;
                end
            end
            ST_ENTRY: begin
                // Any key event counts as activity and beats a simultaneous expiry.
                if (pif.key_vld) begin
                    tmr_load = 1'b1;
                    if (is_digit) begin
                        if (pif.count < LEN) begin
                            digits_nxt  = digit_shift;
                            count_nxt   = pif.count + 3'd1;
                            key_num_nxt = pif.key_val[2:0];
                        end
                    end else if (pif.key_val == KEY_CLR) begin
                        digits_nxt = '0;
                        count_nxt  = 3'd0;
                    end else if (pif.key_val == KEY_ENT && pif.count == LEN) begin
                        state_nxt = ST_CHECK;
                    end
                end else if (tmr_done) begin
                    state_nxt  = ST_IDLE;
                    digits_nxt = '0;
                    count_nxt  = 3'd0;
                end
            end
            ST_CHECK: begin
                success_nxt = (digits == PASSCODE);
                if (digits == PASSCODE) begin
                    fail_nxt = '0;
                end else if (fail_cnt < FAIL_LIM) begin
                    fail_nxt = fail_cnt + FAIL_ONE;
                end
                state_nxt = ST_RESULT;
                tmr_load  = 1'b1;
                tmr_val   = T_HOLD;
            end
            ST_RESULT: begin
                if (tmr_done) begin
                    digits_nxt  = '0;
                    count_nxt   = 3'd0;
                    success_nxt = 1'b0;
                    if (fail_cnt >= FAIL_LIM) begin
                        state_nxt = ST_LOCK;
                        tmr_load  = 1'b1;
                        tmr_val   = T_LOCK;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_LOCK: begin
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                    fail_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs come from the next-state values so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits           <= '0;
            fail_cnt         <= '0;
            pif.count        <= 3'd0;
            pif.key_num      <= 3'd0;
            pif.success      <= 1'b0;
            pif.inputing     <= 1'b0;
            pif.input_finish <= 1'b0;
            pif.alarm        <= 1'b0;
        end else begin
            digits           <= digits_nxt;
            fail_cnt         <= fail_nxt;
            pif.count        <= count_nxt;
            pif.key_num      <= key_num_nxt;
            pif.success      <= success_nxt;
            pif.inputing     <= (state_nxt == ST_ENTRY);
            pif.input_finish <= (state_nxt == ST_RESULT);
            pif.alarm        <= (state_nxt == ST_LOCK);
        end
    end

endmodule

// File: tb/tb_passcode_ctrl.sv
// Testbench for passcode_ctrl: directed scenarios plus a randomized run checked
// against a deadline-based behavioural model of the keypad lock.
module tb_passcode_ctrl;

    localparam int CODE_LEN    = 4;
    localparam int PASS_I      = 'o1234;
    localparam int TIMEOUT_CYC = 100;
    localparam int HOLD_CYC    = 20;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYC    = 40;

    localparam int PH_IDLE = 0, PH_ENTRY = 1, PH_CHECK = 2, PH_RESULT = 3, PH_LOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    passcode_ctrl_if pif();

    passcode_ctrl #(
        .CODE_LEN    (CODE_LEN),
        .PASSCODE    (12'(PASS_I)),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYC    (LOCK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits as a queue, timing as absolute deadlines.
    int     m_q[$];
    int     m_phase;
    longint m_n, m_dl;
    int     m_key_num, m_fails;
    bit     m_success;

    task automatic model_reset();
        m_q.delete();
        m_phase = PH_IDLE; m_n = 0; m_dl = 0;
        m_key_num = 0; m_fails = 0; m_success = 0;
    endtask

    task automatic model_step();
        bit vld;
        int val;
        bit match;
        vld = pif.key_vld;
        val = int'(pif.key_val);
        m_n++;
        case (m_phase)
            PH_IDLE: if (vld && val < 8) begin
                m_q.delete(); m_q.push_back(val); m_key_num = val;
                m_phase = PH_ENTRY; m_dl = m_n + TIMEOUT_CYC;
            end
            PH_ENTRY: if (vld) begin
                m_dl = m_n + TIMEOUT_CYC;
                if (val < 8) begin
                    if (m_q.size() < CODE_LEN) begin m_q.push_back(val); m_key_num = val; end
                end else if (val == 8) m_q.delete();
                else if (val == 9 && m_q.size() == CODE_LEN) m_phase = PH_CHECK;
            end else if (m_n == m_dl) begin
                m_phase = PH_IDLE; m_q.delete();
            end
            PH_CHECK: begin
                match = 1'b1;
                for (int i = 0; i < CODE_LEN; i++)
                    if (m_q[i] != ((PASS_I >> (3 * (CODE_LEN - 1 - i))) & 7)) match = 1'b0;
                m_success = match;
                if (match) m_fails = 0;
                else if (m_fails < MAX_FAIL) m_fails++;
                m_phase = PH_RESULT; m_dl = m_n + HOLD_CYC;
            end
            PH_RESULT: if (m_n == m_dl) begin
                m_success = 0; m_q.delete();
                if (m_fails >= MAX_FAIL) begin m_phase = PH_LOCK; m_dl = m_n + LOCK_CYC; end
                else m_phase = PH_IDLE;
            end
            PH_LOCK: if (m_n == m_dl) begin
                m_phase = PH_IDLE; m_fails = 0;
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        pif.key_vld = 1'b1; pif.key_val = v;
        @(negedge clk);
        pif.key_vld = 1'b0;
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        press(4'(a)); press(4'(b)); press(4'(c)); press(4'(d)); press(4'd9);
    endtask

    task automatic test_reset();
        pif.key_vld = 1'b1; pif.key_val = 4'd1;
        rst = 1'b1;
        idle(3);
        checks++;
        if ({pif.count, pif.key_num, pif.inputing, pif.input_finish, pif.success, pif.alarm} !== 10'd0) begin
            errors++; $display("FAIL reset_outputs got count=%0d key_num=%0d flags=%b%b%b%b required all 0",
                pif.count, pif.key_num, pif.inputing, pif.input_finish, pif.success, pif.alarm);
        end
        rst = 1'b0; pif.key_vld = 1'b0;
        idle(1);
        checks++;
        if (pif.inputing !== 1'b0 || pif.count !== 3'd0) begin
            errors++; $display("FAIL reset_release inputing=%b count=%0d required 0/0", pif.inputing, pif.count);
        end
    endtask

    task automatic test_correct_code();
        for (int d = 1; d <= 4; d++) begin
            press(4'(d));
            checks++;
            if (pif.count !== 3'(d) || pif.key_num !== 3'(d) || pif.inputing !== 1'b1) begin
                errors++; $display("FAIL correct_digit%0d count=%0d key_num=%0d inputing=%b required %0d/%0d/1",
                    d, pif.count, pif.key_num, pif.inputing, d, d);
            end
        end
        press(4'd9);
        checks++;
        if (pif.input_finish !== 1'b0) begin
            errors++; $display("FAIL correct_check_cycle input_finish=%b required 0", pif.input_finish);
        end
        idle(1);
        checks++;
        if (pif.input_finish !== 1'b1 || pif.success !== 1'b1) begin
            errors++; $display("FAIL correct_result input_finish=%b success=%b required 1/1", pif.input_finish, pif.success);
        end
        idle(HOLD_CYC - 1);
        checks++;
        if (pif.input_finish !== 1'b1) begin
            errors++; $display("FAIL correct_hold input_finish=%b required 1", pif.input_finish);
        end
        idle(1);
        checks++;
        if (pif.input_finish !== 1'b0 || pif.success !== 1'b0 || pif.count !== 3'd0 || pif.inputing !== 1'b0) begin
            errors++; $display("FAIL correct_to_idle input_finish=%b success=%b count=%0d inputing=%b required 0/0/0/0",
                pif.input_finish, pif.success, pif.count, pif.inputing);
        end
    endtask

    task automatic test_lockout();
        for (int a = 1; a <= 3; a++) begin
            enter_code(1, 2, 3, 5);
            idle(1);
            checks++;
            if (pif.input_finish !== 1'b1 || pif.success !== 1'b0) begin
                errors++; $display("FAIL lock_attempt%0d input_finish=%b success=%b required 1/0", a, pif.input_finish, pif.success);
            end
            idle(HOLD_CYC);
            checks++;
            if (pif.alarm !== (a == 3)) begin
                errors++; $display("FAIL lock_alarm_after%0d alarm=%b required %0d", a, pif.alarm, a == 3);
            end
        end
        press(4'd5);
        checks++;
        if (pif.count !== 3'd0 || pif.alarm !== 1'b1 || pif.inputing !== 1'b0) begin
            errors++; $display("FAIL lock_key_ignored count=%0d alarm=%b inputing=%b required 0/1/0", pif.count, pif.alarm, pif.inputing);
        end
        idle(LOCK_CYC - 3);
        checks++;
        if (pif.alarm !== 1'b1) begin
            errors++; $display("FAIL lock_held alarm=%b required 1", pif.alarm);
        end
        idle(1);
        checks++;
        if (pif.alarm !== 1'b0) begin
            errors++; $display("FAIL lock_release alarm=%b required 0", pif.alarm);
        end
    endtask

    task automatic test_overflow();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd7);
        checks++;
        if (pif.count !== 3'd4 || pif.key_num !== 3'd4) begin
            errors++; $display("FAIL overflow_digit count=%0d key_num=%0d required 4/4", pif.count, pif.key_num);
        end
        press(4'd9);
        idle(1);
        checks++;
        if (pif.success !== 1'b1 || pif.input_finish !== 1'b1) begin
            errors++; $display("FAIL overflow_result success=%b input_finish=%b required 1/1", pif.success, pif.input_finish);
        end
        idle(HOLD_CYC);
    endtask

    task automatic test_clear();
        press(4'd1); press(4'd2); press(4'd8);
        checks++;
        if (pif.count !== 3'd0 || pif.inputing !== 1'b1) begin
            errors++; $display("FAIL clear_count count=%0d inputing=%b required 0/1", pif.count, pif.inputing);
        end
        press(4'd9);
        checks++;
        if (pif.inputing !== 1'b1 || pif.input_finish !== 1'b0) begin
            errors++; $display("FAIL clear_short_enter inputing=%b input_finish=%b required 1/0", pif.inputing, pif.input_finish);
        end
        enter_code(1, 2, 3, 4);
        idle(1);
        checks++;
        if (pif.success !== 1'b1) begin
            errors++; $display("FAIL clear_result success=%b required 1", pif.success);
        end
        idle(HOLD_CYC);
    endtask

    task automatic test_timeout();
        press(4'd5);
        idle(TIMEOUT_CYC - 1);
        checks++;
        if (pif.inputing !== 1'b1 || pif.count !== 3'd1) begin
            errors++; $display("FAIL timeout_before inputing=%b count=%0d required 1/1", pif.inputing, pif.count);
        end
        idle(1);
        checks++;
        if (pif.inputing !== 1'b0 || pif.count !== 3'd0) begin
            errors++; $display("FAIL timeout_expire inputing=%b count=%0d required 0/0", pif.inputing, pif.count);
        end
        press(4'd5);
        idle(TIMEOUT_CYC - 2);
        press(4'd6);
        checks++;
        if (pif.inputing !== 1'b1 || pif.count !== 3'd2 || pif.key_num !== 3'd6) begin
            errors++; $display("FAIL timeout_key_wins inputing=%b count=%0d key_num=%0d required 1/2/6",
                pif.inputing, pif.count, pif.key_num);
        end
        idle(TIMEOUT_CYC - 1);
        checks++;
        if (pif.inputing !== 1'b1) begin
            errors++; $display("FAIL timeout_reloaded inputing=%b required 1", pif.inputing);
        end
        idle(1);
        checks++;
        if (pif.inputing !== 1'b0 || pif.count !== 3'd0) begin
            errors++; $display("FAIL timeout_second inputing=%b count=%0d required 0/0", pif.inputing, pif.count);
        end
    endtask

    task automatic test_reset_mid_result();
        for (int a = 0; a < 2; a++) begin
            enter_code(1, 2, 3, 5);
            idle(1 + HOLD_CYC);
        end
        enter_code(1, 2, 3, 4);
        idle(1);
        checks++;
        if (pif.success !== 1'b1 || pif.input_finish !== 1'b1) begin
            errors++; $display("FAIL midrst_pre success=%b input_finish=%b required 1/1", pif.success, pif.input_finish);
        end
        enter_code(1, 2, 3, 5);
        idle(0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pif.count, pif.key_num, pif.inputing, pif.input_finish, pif.success, pif.alarm} !== 10'd0) begin
            errors++; $display("FAIL midrst_async count=%0d key_num=%0d flags=%b%b%b%b required all 0",
                pif.count, pif.key_num, pif.inputing, pif.input_finish, pif.success, pif.alarm);
        end
        @(negedge clk);
        rst = 1'b0; pif.key_vld = 1'b1; pif.key_val = 4'd3;
        @(negedge clk);
        pif.key_vld = 1'b0;
        checks++;
        if (pif.count !== 3'd1 || pif.key_num !== 3'd3 || pif.inputing !== 1'b1) begin
            errors++; $display("FAIL midrst_first_key count=%0d key_num=%0d inputing=%b required 1/3/1",
                pif.count, pif.key_num, pif.inputing);
        end
        for (int a = 0; a < 2; a++) begin
            press(4'd8);
            enter_code(1, 2, 3, 5);
            idle(1 + HOLD_CYC);
            checks++;
            if (pif.alarm !== 1'b0) begin
                errors++; $display("FAIL midrst_no_residual attempt%0d alarm=%b required 0", a, pif.alarm);
            end
        end
    endtask

    typedef struct packed { logic vld; logic [3:0] val; } stim_t;

    task automatic test_random();
        stim_t sq[$];
        int kind, dig, n;
        bit good;
        for (int ep = 0; ep < 80; ep++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                good = ($urandom_range(0, 1) == 1);
                for (int i = 0; i < CODE_LEN; i++) begin
                    dig = good ? ((PASS_I >> (3 * (CODE_LEN - 1 - i))) & 7) : int'($urandom_range(0, 7));
                    sq.push_back({1'b1, 4'(dig)});
                    n = $urandom_range(0, 2);
                    repeat (n) sq.push_back(5'd0);
                end
                if ($urandom_range(0, 7) == 0) sq.push_back({1'b1, 4'($urandom_range(0, 15))});
                sq.push_back({1'b1, 4'd9});
            end else if (kind == 8) begin
                sq.push_back({1'b1, 4'($urandom_range(0, 7))});
                n = TIMEOUT_CYC - 2 + $urandom_range(0, 3);
                repeat (n) sq.push_back(5'd0);
                sq.push_back({1'b1, 4'($urandom_range(0, 7))});
            end
            n = (kind == 9) ? 50 : $urandom_range(0, 40);
            for (int i = 0; i < n; i++)
                sq.push_back(($urandom_range(0, 3) == 0) ? {1'b1, 4'($urandom_range(0, 15))} : 5'd0);
        end
        foreach (sq[k]) begin
            @(negedge clk);
            checks++;
            if (pif.count !== 3'(m_q.size()) || pif.key_num !== 3'(m_key_num)) begin
                errors++; $display("FAIL rand_count step %0d count=%0d key_num=%0d required %0d/%0d",
                    k, pif.count, pif.key_num, m_q.size(), m_key_num);
            end
            checks++;
            if (pif.inputing !== (m_phase == PH_ENTRY) || pif.input_finish !== (m_phase == PH_RESULT)
                || pif.alarm !== (m_phase == PH_LOCK)) begin
                errors++; $display("FAIL rand_phase step %0d inputing=%b input_finish=%b alarm=%b required phase %0d",
                    k, pif.inputing, pif.input_finish, pif.alarm, m_phase);
            end
            checks++;
            if (pif.success !== m_success) begin
                errors++; $display("FAIL rand_success step %0d success=%b required %b", k, pif.success, m_success);
            end
            pif.key_vld = sq[k].vld;
            pif.key_val = sq[k].val;
        end
        @(negedge clk);
        pif.key_vld = 1'b0;
    endtask

    initial begin
        pif.key_vld = 1'b0;
        pif.key_val = 4'd0;
        test_reset();
        test_correct_code();
        test_lockout();
        test_overflow();
        test_clear();
        test_timeout();
        test_reset_mid_result();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/passcode_ctrl.md
PASSCODE_CTRL -- requirements
Module: passcode_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, giving the digits per code (1..7).
REQ-002 SHALL have parameter PASSCODE, default 12'o1234, holding CODE_LEN 3-bit digits with the first-entered digit in the MSBs.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 250_000_000, giving the idle cycles allowed during entry.
REQ-004 SHALL have parameter HOLD_CYC, default 150_000_000, giving the result display cycles.
REQ-005 SHALL have parameter MAX_FAIL, default 3, giving the consecutive failures that trigger lockout.
REQ-006 SHALL have parameter LOCK_CYC, default 500_000_000, giving the lockout cycles.
REQ-007 SHALL have port clk, input, 1 bit: 50 MHz system clock; one clock domain only.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port key_vld, input, 1 bit: single-cycle pulse, debounced key event.
REQ-010 SHALL have port key_val, input, 4 bits: 0-7 are digits, 8 is clear, 9 is enter, and 10-15 are ignored.
REQ-011 SHALL have port count, output, 3 bits: digits currently entered.
REQ-012 SHALL have port key_num, output, 3 bits: last accepted digit.
REQ-013 SHALL have port inputing, output, 1 bit: high while in ENTRY.
REQ-014 SHALL have port input_finish, output, 1 bit: high while in RESULT.
REQ-015 SHALL have port success, output, 1 bit: code matched; valid while input_finish is high.
REQ-016 SHALL have port alarm, output, 1 bit: high while in LOCK.

Function
REQ-017 SHALL use the states IDLE, ENTRY, CHECK, RESULT and LOCK, held in one registered state variable.
REQ-018 IDLE: a digit key SHALL go to ENTRY, with count=1 and key_num=digit on the next clock; clear, enter and invalid keys SHALL be ignored.
REQ-019 ENTRY: a digit with count<CODE_LEN SHALL shift into the digit register, increment count and update key_num, all on the next clock.
REQ-020 ENTRY: a digit with count==CODE_LEN SHALL be ignored, with no wrap-around.
REQ-021 ENTRY: clear SHALL zero count and the digit register and SHALL remain in ENTRY.
REQ-022 ENTRY: enter with count==CODE_LEN SHALL go to CHECK; enter with count<CODE_LEN SHALL be ignored.
REQ-023 ENTRY: the timeout counter SHALL reload on every accepted key_vld.
REQ-024 ENTRY: on expiry after TIMEOUT_CYC cycles, the block SHALL go to IDLE with count=0; a key_vld in the expiry cycle wins, and the timer reloads.
REQ-025 CHECK SHALL last exactly one cycle: it compares the full CODE_LEN*3-bit register to PASSCODE, registers success, then goes to RESULT.
REQ-026 Total latency SHALL be 2 clocks: enter accepted -> input_finish high.
REQ-027 RESULT SHALL hold for HOLD_CYC cycles and ignore all keys, then go to IDLE, clearing count, success and the digit register.
REQ-028 The fail counter SHALL increment on a mismatch in CHECK and clear on a match.
REQ-029 If the fail counter reaches MAX_FAIL, the exit from RESULT SHALL go to LOCK instead of IDLE.
REQ-030 LOCK: alarm=1, all keys ignored; after LOCK_CYC cycles the block SHALL go to IDLE, clearing the fail counter.
REQ-031 The counters SHALL be sized $clog2 of the largest cycle parameter, count down, and saturate at zero.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 Asserting rst SHALL asynchronously force state=IDLE, count=0, key_num=0, inputing=0, input_finish=0, success=0, alarm=0, and clear the fail counter, timers and digit register.
REQ-034 Reset mid-ENTRY, mid-RESULT or mid-LOCK SHALL abandon the operation and keep no residual fail count.
REQ-035 On deassertion, the first key_vld SHALL be honoured from the next edge onward.

Structure
REQ-036 A shared package SHALL hold the state enum typedef and the key code constants: KEY_CLR=8 and KEY_ENT=9.
REQ-037 One sub-module, cyc_timer (loadable down-counter with a done pulse), SHALL be instantiated and reused for the timeout, hold and lock timing.

Verification
REQ-038 Scenario: keys 1,2,3,4,enter -> count steps 1..4, key_num=4, success=1 and input_finish=1 two clocks after enter, IDLE after HOLD_CYC.
REQ-039 Scenario: keys 1,2,3,5,enter, three times -> success=0 each time; alarm=1 after the third RESULT, cleared after LOCK_CYC; keys during LOCK do not change count.
REQ-040 Scenario: keys 1,2,3,4,7 -> count stays 4 and key_num=4; enter -> success=1.
REQ-041 Scenario: keys 1,2,clear,1,2,3,4,enter -> count goes to 0 after clear, and success=1.
REQ-042 Scenario: TIMEOUT_CYC=100, key 5 then no keys -> IDLE with count=0 at cycle 100; a key exactly at cycle 100 -> stays ENTRY with count=2.
REQ-043 Scenario: rst asserted during RESULT with success=1 -> all outputs 0 immediately, without waiting for a clock edge.
